// File: rtl/top_mux_drain.sv
// top_mux_drain: registered N:1 drain multiplexer for the systolic result path.
// Captures a bank of N BW-bit channel words on load, then streams a run of
// them (start channel, length, wrap modulo N) over a valid/ready port.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   in_a            channel bank, channel i = in_a[(i+1)*BW-1 -: BW]
//   in_valid        load request
//   in_ready        idle; a load is accepted this cycle if in_valid
//   select, len     start channel and run length, sampled on load
//   out_a, out_idx  current word and its channel index
//   out_valid       out_a/out_idx valid
//   out_last        current word is the final word of the run
//   out_ready       consumer accepts the beat
//   done            one-cycle pulse after the final beat is accepted
module top_mux_drain #(
    parameter int unsigned BW  = 8,
    parameter int unsigned N   = 8,
    // Derived index width; leave at its default.
    parameter int unsigned SEL = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BW*N-1:0] in_a,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SEL-1:0]  select,
    input  logic [SEL:0]    len,
    output logic [BW-1:0]   out_a,
    output logic [SEL-1:0]  out_idx,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic            done
);

    localparam logic [SEL:0]   N_L      = (SEL+1)'(N);
    localparam logic [SEL:0]   ONE_L    = (SEL+1)'(1);
    localparam logic [SEL-1:0] LAST_IDX = SEL'(N-1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [BW*N-1:0] bank_q, bank_d;
    logic [SEL-1:0]  idx_q, idx_d;
    logic [SEL:0]    rem_q, rem_d;

    logic [BW-1:0]   out_a_d;
    logic [SEL-1:0]  out_idx_d;
    logic            out_valid_d;
    logic            out_last_d;
    logic            in_ready_d;
    logic            done_d;

    logic            beat_c;
    logic [SEL-1:0]  start_c;
    logic [SEL:0]    len_eff_c;
    logic [SEL-1:0]  idx_inc_c;
    logic [SEL:0]    rem_dec_c;
    logic [BW-1:0]   in_word_c;
    logic [BW-1:0]   bank_word_c;

    // Beat handshake and run-parameter normalisation.
    always_comb begin
        beat_c    = out_valid & out_ready;
        start_c   = ({1'b0, select} >= N_L) ? '0 : select;
        len_eff_c = ((len == '0) || (len > N_L)) ? N_L : len;
        idx_inc_c = (idx_q == LAST_IDX) ? '0 : idx_q + SEL'(1);
        rem_dec_c = rem_q - ONE_L;
    end

    // First word comes straight from the incoming bank at the start channel.
    always_comb begin
        in_word_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (start_c == SEL'(i)) begin
                in_word_c = in_a[i*BW +: BW];
            end
        end
    end

    // Subsequent words come from the captured bank at the next index.
    always_comb begin
        bank_word_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (idx_inc_c == SEL'(i)) begin
                bank_word_c = bank_q[i*BW +: BW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_c && out_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values; everything holds unless loaded or beaten.
    always_comb begin
        bank_d      = bank_q;
        idx_d       = idx_q;
        rem_d       = rem_q;
        out_a_d     = out_a;
        out_idx_d   = out_idx;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        in_ready_d  = in_ready;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bank_d      = in_a;
                    idx_d       = start_c;
                    rem_d       = len_eff_c;
                    out_a_d     = in_word_c;
                    out_idx_d   = start_c;
                    out_last_d  = (len_eff_c == ONE_L);
                    out_valid_d = 1'b1;
                    in_ready_d  = 1'b0;
                end
            end
            DRAIN: begin
                if (beat_c) begin
                    if (out_last) begin
                        rem_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = idx_inc_c;
                        rem_d      = rem_dec_c;
                        out_a_d    = bank_word_c;
                        out_idx_d  = idx_inc_c;
                        out_last_d = (rem_dec_c == ONE_L);
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q    <= '0;
            idx_q     <= '0;
            rem_q     <= '0;
            out_a     <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            done      <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            out_a     <= out_a_d;
            out_idx   <= out_idx_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            in_ready  <= in_ready_d;
            done      <= done_d;
        end
    end

endmodule
